// File: rtl/memoria_datos_bytes.sv
// MIPS data memory with byte/half/word access, sign/zero extension, fault flags,
// a sequential clear after reset and an independent debug read port.
module memoria_datos_bytes #(
    parameter int NBITS  = 32,
    parameter int CELDAS = 1024,
    parameter int NB_IDX = $clog2(CELDAS)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NBITS-1:0]  i_ALUDireccion,
    input  logic [NBITS-1:0]  i_DatoRegistro,
    input  logic              i_MemWrite,
    input  logic              i_MemRead,
    input  logic [1:0]        i_Ancho,
    input  logic              i_Signo,
    input  logic [NB_IDX-1:0] i_DebugDir,
    output logic [NBITS-1:0]  o_DatoLeido,
    output logic [NBITS-1:0]  o_DebugDato,
    output logic              o_Desalineado,
    output logic              o_FueraRango,
    output logic              o_Ocupado
);
    localparam logic [NBITS-3:0]  LIMITE     = (NBITS-2)'(CELDAS);
    localparam logic [NB_IDX:0]   LIMITE_DBG = (NB_IDX+1)'(CELDAS);
    localparam logic [NB_IDX-1:0] ULTIMA     = NB_IDX'(CELDAS - 1);

    typedef enum logic {CLEAR, READY} estado_t;

    estado_t           estado, estado_sig;
    logic [NB_IDX-1:0] cnt_clr;
    logic [NBITS-1:0]  mem [CELDAS];

    logic [NB_IDX-1:0] idx;
    logic [1:0]        off;
    logic              fuera_rango, desalineado, acceso, falla, lectura, escribe;
    logic [3:0]        be;
    logic [NBITS-1:0]  dato_wr, palabra, dato_carga;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign idx         = i_ALUDireccion[NB_IDX+1:2];
    assign off         = i_ALUDireccion[1:0];
    assign fuera_rango = i_ALUDireccion[NBITS-1:2] >= LIMITE;
    assign o_Ocupado   = (estado == CLEAR);

    // Encoding 10 is treated as a word access.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        desalineado = 1'b0;
        be          = 4'b1111;
        dato_wr     = i_DatoRegistro;
        case (i_Ancho)
            2'b00: begin
                be      = 4'b0001 << off;
                dato_wr = {4{i_DatoRegistro[7:0]}};
            end
            2'b01: begin
                desalineado = off[0];
                be          = off[1] ? 4'b1100 : 4'b0011;
                dato_wr     = {2{i_DatoRegistro[15:0]}};
            end
            default: desalineado = (off != 2'b00);
        endcase
    end

    assign acceso  = (estado == READY) && (i_MemRead || i_MemWrite);
    assign falla   = desalineado || fuera_rango;
    assign lectura = (estado == READY) && i_MemRead;
    assign escribe = (estado == READY) && i_MemWrite && !i_MemRead && !falla;

    assign palabra  = fuera_rango ? '0 : mem[idx];
    assign byte_sel = palabra[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? palabra[31:16] : palabra[15:0];

    always_comb begin
        dato_carga = palabra;
        case (i_Ancho)
            2'b00:   dato_carga = {{(NBITS-8){i_Signo & byte_sel[7]}}, byte_sel};
            2'b01:   dato_carga = {{(NBITS-16){i_Signo & half_sel[15]}}, half_sel};
            default: dato_carga = palabra;
        endcase
    end

    always_comb begin
        estado_sig = estado;
        if (estado == CLEAR && cnt_clr == ULTIMA)
            estado_sig = READY;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_reset_n) begin
            estado  <= CLEAR;
            cnt_clr <= '0;
        end else begin
            estado <= estado_sig;
            if (estado == CLEAR)
                cnt_clr <= cnt_clr + NB_IDX'(1);
        end
    end

    // NOTE: the array has no reset; the CLEAR sweep zeroes it one word per cycle instead.
    always_ff @(posedge i_clk) begin
        if (estado == CLEAR) begin
            mem[cnt_clr] <= '0;
        end else if (escribe) begin
            for (int k = 0; k < 4; k++)
                if (be[k])
                    mem[idx][8*k +: 8] <= dato_wr[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_DatoLeido   <= '0;
            o_DebugDato   <= '0;
            o_Desalineado <= 1'b0;
            o_FueraRango  <= 1'b0;
        end else begin
            o_Desalineado <= acceso && desalineado;
            o_FueraRango  <= acceso && fuera_rango;
            if (lectura)
                o_DatoLeido <= falla ? '0 : dato_carga;
            // Reads the pre-edge word, so a same-edge store to it shows old data.
            o_DebugDato <= ({1'b0, i_DebugDir} < LIMITE_DBG) ? mem[i_DebugDir] : '0;
        end
    end
endmodule

// File: tb/tb_memoria_datos_bytes.sv
// Self-checking bench for memoria_datos_bytes: directed steps plus random accesses
// compared against a byte-array reference model.
module tb_memoria_datos_bytes;
    localparam int CELDAS = 16;
    localparam int NB_IDX = $clog2(CELDAS);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic              mem_write = 1'b0;
    logic              mem_read = 1'b0;
    logic [1:0]        ancho = 2'b11;
    logic              signo = 1'b0;
    logic [NB_IDX-1:0] dbg_dir = '0;
    logic [31:0]       dato_leido, debug_dato;
    logic              desalineado, fuera_rango, ocupado;

    int n_pass = 0;
    int n_fail = 0;

    logic [7:0]  ref_mem [4*CELDAS];
    logic [31:0] exp_dato;
    logic        exp_mis, exp_oor;

    memoria_datos_bytes #(.NBITS(32), .CELDAS(CELDAS)) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_ALUDireccion(addr),
        .i_DatoRegistro(wdata),
        .i_MemWrite(mem_write),
        .i_MemRead(mem_read),
        .i_Ancho(ancho),
        .i_Signo(signo),
        .i_DebugDir(dbg_dir),
        .o_DatoLeido(dato_leido),
        .o_DebugDato(debug_dato),
        .o_Desalineado(desalineado),
        .o_FueraRango(fuera_rango),
        .o_Ocupado(ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4*CELDAS; i++) ref_mem[i] = 8'h00;
        exp_dato = '0;
    endtask

    // Reference behaviour expressed on a flat little-endian byte array.
    task automatic model(input bit rd, input bit wr, input logic [1:0] an, input bit sg,
                         input logic [31:0] a, input logic [31:0] d);
        int nb;
        bit mis, oor;
        logic [31:0] v;
        nb  = (an == 2'b00) ? 1 : (an == 2'b01) ? 2 : 4;
        oor = (a / 4) >= CELDAS;
        mis = (a % nb) != 0;
        exp_mis = (rd || wr) && mis;
        exp_oor = (rd || wr) && oor;
        if (rd) begin
            if (mis || oor) exp_dato = '0;
            else begin
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
                if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                exp_dato = v;
            end
        end else if (wr && !mis && !oor) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(d >> (8 * i));
        end
    endtask

    task automatic access(input string tag, input bit rd, input bit wr, input logic [1:0] an,
                          input bit sg, input logic [31:0] a, input logic [31:0] d,
                          input logic [NB_IDX-1:0] dbg);
        logic [31:0] exp_dbg;
        mem_read  = rd;
        mem_write = wr;
        ancho     = an;
        signo     = sg;
        addr      = a;
        wdata     = d;
        dbg_dir   = dbg;
        exp_dbg   = model_word(int'(dbg));
        model(rd, wr, an, sg, a, d);
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check($sformatf("%s.dato", tag), dato_leido, exp_dato);
        check($sformatf("%s.desal", tag), 32'(desalineado), 32'(exp_mis));
        check($sformatf("%s.rango", tag), 32'(fuera_rango), 32'(exp_oor));
        check($sformatf("%s.debug", tag), debug_dato, exp_dbg);
    endtask

    task automatic wait_clear(input string tag, input int ya_hechos);
        int n;
        n = ya_hechos;
        while (ocupado && n < 200) begin
            step();
            n++;
        end
        check($sformatf("%s.ciclos", tag), 32'(n), 32'(CELDAS));
        model_clear();
    endtask

    initial begin
        int op, sel;
        logic [31:0] a;

        // Reset state
        step();
        step();
        check("rst.dato", dato_leido, 32'h0);
        check("rst.debug", debug_dato, 32'h0);
        check("rst.desal", 32'(desalineado), 32'h0);
        check("rst.rango", 32'(fuera_rango), 32'h0);
        check("rst.ocupado", 32'(ocupado), 32'h1);

        rst_n = 1'b1;
        wait_clear("clear1", 0);
        check("clear1.ocupado", 32'(ocupado), 32'h0);
        for (int k = 0; k < CELDAS; k++) begin
            dbg_dir = NB_IDX'(k);
            step();
            check($sformatf("sweep1[%0d]", k), debug_dato, 32'h0);
        end

        // Directed accesses
        access("sw8", 0, 1, 2'b11, 0, 32'h8, 32'h8899AABB, 4'd2);
        access("lw8", 1, 0, 2'b11, 0, 32'h8, 32'h0, 4'd2);
        check("lw8.const", dato_leido, 32'h8899AABB);
        access("sb9", 0, 1, 2'b00, 0, 32'h9, 32'h000000F0, 4'd2);
        access("lb9", 1, 0, 2'b00, 1, 32'h9, 32'h0, 4'd2);
        check("lb9.const", dato_leido, 32'hFFFFFFF0);
        check("w2.const", debug_dato, 32'h8899F0BB);
        access("lbu9", 1, 0, 2'b00, 0, 32'h9, 32'h0, 4'd2);
        check("lbu9.const", dato_leido, 32'h000000F0);
        access("shA", 0, 1, 2'b01, 0, 32'hA, 32'h00008001, 4'd2);
        access("lhA", 1, 0, 2'b01, 1, 32'hA, 32'h0, 4'd2);
        check("lhA.const", dato_leido, 32'hFFFF8001);
        access("lhuA", 1, 0, 2'b01, 0, 32'hA, 32'h0, 4'd2);
        check("lhuA.const", dato_leido, 32'h00008001);
        access("lw6", 1, 0, 2'b11, 0, 32'h6, 32'h0, 4'd1);
        check("lw6.const", 32'(desalineado), 32'h1);
        access("idle1", 0, 0, 2'b11, 0, 32'h0, 32'h0, 4'd1);
        access("sh5", 0, 1, 2'b01, 0, 32'h5, 32'hFFFF, 4'd1);
        access("idle2", 0, 0, 2'b11, 0, 32'h0, 32'h0, 4'd1);
        access("sw64", 0, 1, 2'b11, 0, 32'(4*CELDAS), 32'hDEADBEEF, 4'd0);
        check("sw64.const", 32'(fuera_rango), 32'h1);
        access("idle3", 0, 0, 2'b11, 0, 32'h0, 32'h0, 4'd0);
        access("rdwr8", 1, 1, 2'b11, 0, 32'h8, 32'h12345678, 4'd2);
        check("rdwr8.const", dato_leido, 32'h8001F0BB);
        access("lw8b", 1, 0, 2'b11, 0, 32'h8, 32'h0, 4'd2);
        access("lwbig", 1, 0, 2'b10, 0, 32'h8000_0008, 32'h0, 4'd2);
        access("bothflt", 1, 0, 2'b11, 0, 32'h0001_0002, 32'h0, 4'd2);

        // Randomized accesses against the reference model
        for (int it = 0; it < 80; it++) begin
            op  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            a   = (sel == 0) ? $urandom() : 32'($urandom_range(0, 4*CELDAS + 7));
            access($sformatf("rnd%0d", it), (op & 1) != 0, (op & 2) != 0,
                   2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, a, $urandom(),
                   NB_IDX'($urandom_range(0, CELDAS - 1)));
        end

        // Reset mid-clear at counter 7
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) step();
        rst_n = 1'b0;
        step();
        check("rst2.ocupado", 32'(ocupado), 32'h1);
        check("rst2.dato", dato_leido, 32'h0);
        rst_n     = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        addr      = 32'h6;
        ancho     = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("clr.ign%0d.dato", k), dato_leido, 32'h0);
            check($sformatf("clr.ign%0d.desal", k), 32'(desalineado), 32'h0);
            check($sformatf("clr.ign%0d.ocupado", k), 32'(ocupado), 32'h1);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wait_clear("clear2", 3);
        for (int k = 0; k < CELDAS; k++) begin
            dbg_dir = NB_IDX'(k);
            step();
            check($sformatf("sweep2[%0d]", k), debug_dato, 32'h0);
        end
        access("post.lw0", 1, 0, 2'b11, 0, 32'h0, 32'h0, 4'd3);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
